// File: rtl/card_dealer.sv
// Five-card hand dealer: an LFSR proposes cards, a used-mask rejects repeats
// and ranks above King, and a three-state FSM collects five accepted cards.
module card_dealer #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       deal,
  input  logic       shuffle,
  output logic [3:0] card1,
  output logic [3:0] card2,
  output logic [3:0] card3,
  output logic [3:0] card4,
  output logic [3:0] card5,
  output logic [1:0] suit1,
  output logic [1:0] suit2,
  output logic [1:0] suit3,
  output logic [1:0] suit4,
  output logic [1:0] suit5,
  output logic       valid,
  output logic       busy,
  output logic [5:0] cards_left,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] lfsr;
  logic [63:0] mask;
  logic [2:0]  k;
  logic [3:0]  rank_q [5];
  logic [1:0]  suit_q [5];
  logic        err_q, err_nxt;
  logic        start, accept;
  logic [5:0]  cand;
  logic        cand_ok;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  assign cand    = lfsr[5:0];
  assign cand_ok = (cand[3:0] <= 4'd12) && !mask[cand];

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    accept    = 1'b0;
    err_nxt   = 1'b0;
    // shuffle overrides everything, including a same-cycle deal
    if (shuffle) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (deal) begin
            if (cards_left >= 6'd5) begin
              state_nxt = DRAW;
              start     = 1'b1;
            end else begin
              err_nxt = 1'b1;
            end
          end
        end
        DRAW: begin
          if (cand_ok) begin
            accept = 1'b1;
            if (k == 3'd4) state_nxt = DONE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lfsr       <= SEED;
      mask       <= '0;
      cards_left <= 6'd52;
      k          <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        rank_q[i] <= '0;
        suit_q[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      lfsr  <= lfsr_step(lfsr);
      err_q <= err_nxt;
      if (start) k <= '0;
      if (shuffle) begin
        mask       <= '0;
        cards_left <= 6'd52;
      end else if (accept) begin
        mask[cand]  <= 1'b1;
        cards_left  <= cards_left - 6'd1;
        rank_q[k]   <= cand[3:0];
        suit_q[k]   <= cand[5:4];
        k           <= k + 3'd1;
      end
    end
  end

  // valid/busy are pure state decodes, so shuffle and reset clear them at once
  assign valid = (state == DONE);
  assign busy  = (state == DRAW);
  assign err   = err_q;

  assign card1 = rank_q[0];
  assign card2 = rank_q[1];
  assign card3 = rank_q[2];
  assign card4 = rank_q[3];
  assign card5 = rank_q[4];
  assign suit1 = suit_q[0];
  assign suit2 = suit_q[1];
  assign suit3 = suit_q[2];
  assign suit4 = suit_q[3];
  assign suit5 = suit_q[4];

endmodule

// File: tb/tb_card_dealer.sv
// Bench for card_dealer: a table of deal/shuffle operations checked against an
// LFSR-driven dealing model, plus hand-written mid-draw shuffle and reset cases.
module tb_card_dealer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       deal = 1'b0;
  logic       shuffle = 1'b0;
  logic [3:0] c1, c2, c3, c4, c5;
  logic [1:0] s1, s2, s3, s4, s5;
  logic       valid, busy, err;
  logic [5:0] cards_left;

  int checks = 0;
  int errors = 0;

  card_dealer #(.SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .deal(deal), .shuffle(shuffle),
    .card1(c1), .card2(c2), .card3(c3), .card4(c4), .card5(c5),
    .suit1(s1), .suit2(s2), .suit3(s3), .suit4(s4), .suit5(s5),
    .valid(valid), .busy(busy), .cards_left(cards_left), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] step(input logic [15:0] v);
    logic [15:0] n;
    n = v >> 1;
    if (v[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  // reference LFSR: reset to SEED, one step per rising edge
  logic [15:0] m_lfsr;
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= step(m_lfsr);
  end

  logic [63:0] m_mask = '0;
  logic [63:0] seen   = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [5:0] slot(input int i);
    case (i)
      0: return {s1, c1};
      1: return {s2, c2};
      2: return {s3, c3};
      3: return {s4, c4};
      default: return {s5, c5};
    endcase
  endfunction

  // Predict the next n accepted cards and the edge (after the deal edge) of the last one
  task automatic predict(input logic [15:0] l0, input int n, output logic [5:0] hand[5],
                         output int edges, output logic [63:0] mask_out, output bit ok);
    logic [15:0] l;
    int found;
    l = l0;
    found = 0;
    edges = 0;
    mask_out = m_mask;
    for (int i = 0; i < 5; i++) hand[i] = '0;
    while (found < n && edges < 5 * 65536) begin
      l = step(l);
      edges++;
      if (l[3:0] <= 4'd12 && !mask_out[l[5:0]]) begin
        mask_out[l[5:0]] = 1'b1;
        hand[found] = l[5:0];
        found++;
      end
    end
    ok = (found == n);
  endtask

  task automatic do_deal(input int exp_left);
    logic [5:0]  hand[5];
    logic [63:0] nmask;
    int          j;
    bit          ok;
    predict(m_lfsr, 5, hand, j, nmask, ok);
    if (!ok) begin
      chk("model_found_hand", 0, 1);
      return;
    end
    deal = 1'b1;
    @(negedge clk);
    deal = 1'b0;
    chk("busy_after_deal", busy, 1);
    chk("valid_cleared", valid, 0);
    repeat (j - 1) @(negedge clk);
    chk("valid_not_early", valid, 0);
    @(negedge clk);
    chk("valid_on_time", valid, 1);
    chk("busy_fell", busy, 0);
    chk("cards_left", cards_left, exp_left);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("card%0d", i + 1), slot(i), hand[i]);
      chk("rank_le_12", (slot(i) & 6'h0F) <= 12, 1);
      chk("card_unique", seen[slot(i)], 0);
      seen[slot(i)] = 1'b1;
    end
    m_mask = nmask;
  endtask

  typedef enum int {OP_DEAL, OP_REJ, OP_COLL} op_e;
  typedef struct {
    op_e op;
    int  exp_left;
  } vec_t;
  vec_t vt[13];

  initial begin
    logic [5:0]  hand[5];
    logic [5:0]  snap[5];
    logic [63:0] nmask;
    int          j;
    bit          ok;

    for (int i = 0; i < 10; i++) vt[i] = '{OP_DEAL, 47 - 5 * i};
    vt[10] = '{OP_REJ, 2};
    vt[11] = '{OP_COLL, 52};
    vt[12] = '{OP_DEAL, 47};

    // reset values, held and after release
    repeat (2) @(negedge clk);
    chk("rst_left", cards_left, 52);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    for (int i = 0; i < 5; i++) chk("rst_card", slot(i), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_left", cards_left, 52);
    chk("idle_valid", valid, 0);

    for (int t = 0; t < 13; t++) begin
      case (vt[t].op)
        OP_DEAL: do_deal(vt[t].exp_left);
        OP_REJ: begin
          for (int i = 0; i < 5; i++) snap[i] = slot(i);
          deal = 1'b1;
          @(negedge clk);
          deal = 1'b0;
          chk("rej_err", err, 1);
          chk("rej_valid", valid, 1);
          chk("rej_busy", busy, 0);
          chk("rej_left", cards_left, vt[t].exp_left);
          @(negedge clk);
          chk("rej_err_pulse", err, 0);
          for (int i = 0; i < 5; i++) chk("rej_card_held", slot(i), snap[i]);
        end
        default: begin
          deal = 1'b1;
          shuffle = 1'b1;
          @(negedge clk);
          deal = 1'b0;
          shuffle = 1'b0;
          chk("coll_left", cards_left, vt[t].exp_left);
          chk("coll_valid", valid, 0);
          chk("coll_busy", busy, 0);
          chk("coll_err", err, 0);
          @(negedge clk);
          chk("coll_stay_idle", busy, 0);
          m_mask = '0;
          seen = '0;
        end
      endcase
    end

    // shuffle after the second card of a hand is written
    predict(m_lfsr, 2, hand, j, nmask, ok);
    chk("model_found_two", ok, 1);
    deal = 1'b1;
    @(negedge clk);
    deal = 1'b0;
    repeat (j) @(negedge clk);
    chk("mid_left", cards_left, 45);
    chk("mid_busy", busy, 1);
    chk("mid_card1", slot(0), hand[0]);
    chk("mid_card2", slot(1), hand[1]);
    shuffle = 1'b1;
    @(negedge clk);
    shuffle = 1'b0;
    chk("shuf_left", cards_left, 52);
    chk("shuf_valid", valid, 0);
    chk("shuf_busy", busy, 0);
    chk("shuf_card1_held", slot(0), hand[0]);
    chk("shuf_card2_held", slot(1), hand[1]);
    m_mask = '0;
    seen = '0;
    do_deal(47);

    // asynchronous reset in the middle of a draw
    deal = 1'b1;
    @(negedge clk);
    chk("ar_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_busy_now", busy, 0);
    chk("ar_valid_now", valid, 0);
    chk("ar_left_now", cards_left, 52);
    for (int i = 0; i < 5; i++) chk("ar_card_now", slot(i), 0);
    repeat (2) @(negedge clk);
    chk("ar_busy_held", busy, 0);
    chk("ar_valid_held", valid, 0);
    chk("ar_err_held", err, 0);
    deal = 1'b0;
    rst = 1'b0;
    m_mask = '0;
    seen = '0;
    do_deal(47);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
